// File: rtl/preg_wb_arbiter_pkg.sv
// Shared types for the physical-register writeback arbiter: one buffered
// result entry plus sizing limits used by the arbiter and its source FIFOs.
`ifndef PREG_LENGTH
`define PREG_LENGTH 6
`endif

package preg_wb_arbiter_pkg;

    localparam int PREG_W      = `PREG_LENGTH;
    localparam int DATA_W      = 64;
    localparam int MAX_NUM_SRC = 8;

    typedef struct packed {
        logic [PREG_W-1:0] idx;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Preg 0 is hardwired zero, so results aimed at it are never buffered.
    function automatic logic wb_keep(input logic wen, input logic [PREG_W-1:0] idx);
        return wen & (idx != {PREG_W{1'b0}});
    endfunction

endpackage

// File: rtl/preg_wb_arbiter_if.sv
// Bus bundle between the FU result sources, the writeback arbiter and the
// two register-file write ports.
interface preg_wb_arbiter_if #(
    parameter int NUM_SRC = 4,
    parameter int PREG_W  = preg_wb_arbiter_pkg::PREG_W
);

    logic                      flush;
    logic [NUM_SRC-1:0]        src_valid;
    logic [NUM_SRC-1:0]        src_ready;
    logic [NUM_SRC-1:0]        src_wen;
    logic [NUM_SRC*PREG_W-1:0] src_idx;
    logic [NUM_SRC*64-1:0]     src_data;

    logic                      write0_en;
    logic [PREG_W-1:0]         write0_idx;
    logic [63:0]               write0_data;
    logic                      write1_en;
    logic [PREG_W-1:0]         write1_idx;
    logic [63:0]               write1_data;

    modport master (
        output flush, src_valid, src_wen, src_idx, src_data,
        input  src_ready,
        input  write0_en, write0_idx, write0_data,
        input  write1_en, write1_idx, write1_data
    );

    modport slave (
        input  flush, src_valid, src_wen, src_idx, src_data,
        output src_ready,
        output write0_en, write0_idx, write0_data,
        output write1_en, write1_idx, write1_data
    );

endinterface

// File: rtl/preg_wb_arbiter_src_fifo.sv
// Per-source result buffer: DEPTH-entry synchronous FIFO of wb_entry_t with
// flush. Callers must not push while full; a push while full is ignored.
module wb_src_fifo
    import preg_wb_arbiter_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush_i,
    input  logic             push_i,
    input  wb_entry_t        push_entry_i,
    input  logic             pop_i,
    output wb_entry_t        head_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push_s;
    logic             do_pop_s;

    // Next-state for pointers and occupancy; flush wins over push and pop.
    always_comb begin
        do_push_s = push_i & (count_q != CNT_W'(DEPTH)) & ~flush_i;
        do_pop_s  = pop_i & (count_q != CNT_W'(0)) & ~flush_i;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush_i) begin
            wr_ptr_d = PTR_W'(0);
            rd_ptr_d = PTR_W'(0);
            count_d  = CNT_W'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push_s) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == CNT_W'(0));
    assign count_o = count_q;

endmodule

// File: rtl/preg_wb_arbiter.sv
// Writeback arbiter: buffers FU results per source and issues up to two
// register-file writes per cycle, round-robin over the FIFO heads.
module preg_wb_arbiter
    import preg_wb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DEPTH   = 2,
    parameter int PREG_W  = preg_wb_arbiter_pkg::PREG_W
) (
    input  logic             clock,
    input  logic             reset_n,
    preg_wb_arbiter_if.slave bus
);

    localparam int SRC_W = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t          push_entry_s [NUM_SRC];
    wb_entry_t          head_s       [NUM_SRC];
    logic [CNT_W-1:0]   count_s      [NUM_SRC];
    logic [NUM_SRC-1:0] push_s;
    logic [NUM_SRC-1:0] pop_s;
    logic [NUM_SRC-1:0] empty_s;
    logic [NUM_SRC-1:0] src_ready_s;

    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SRC_W:0]     scan_pos_s;
    logic [SRC_W-1:0]   scan_src_s;
    logic               found_a_s, found_b_s;
    logic [SRC_W-1:0]   sel_a_s, sel_b_s;
    logic               grant_a_s, grant_b_s;

    logic               wr0_en_q, wr0_en_d;
    logic [PREG_W-1:0]  wr0_idx_q, wr0_idx_d;
    logic [63:0]        wr0_data_q, wr0_data_d;
    logic               wr1_en_q, wr1_en_d;
    logic [PREG_W-1:0]  wr1_idx_q, wr1_idx_d;
    logic [63:0]        wr1_data_q, wr1_data_d;

    function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] s);
        if (s == SRC_W'(NUM_SRC - 1)) begin
            return SRC_W'(0);
        end else begin
            return s + SRC_W'(1);
        end
    endfunction

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign push_entry_s[g] = {bus.src_idx[g*PREG_W +: PREG_W], bus.src_data[g*64 +: 64]};
        // Ready depends only on stored occupancy, never on this cycle's pop.
        assign src_ready_s[g]  = (count_s[g] < CNT_W'(DEPTH));
        assign push_s[g]       = bus.src_valid[g] & src_ready_s[g]
                               & wb_keep(bus.src_wen[g], push_entry_s[g].idx);

        wb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clock        (clock),
            .reset_n      (reset_n),
            .flush_i      (bus.flush),
            .push_i       (push_s[g]),
            .push_entry_i (push_entry_s[g]),
            .pop_i        (pop_s[g]),
            .head_o       (head_s[g]),
            .empty_o      (empty_s[g]),
            .count_o      (count_s[g])
        );
    end

    assign bus.src_ready = src_ready_s;

    // Round-robin scan from rr_ptr: first two non-empty heads become grants A and B.
    always_comb begin
        found_a_s  = 1'b0;
        found_b_s  = 1'b0;
        sel_a_s    = SRC_W'(0);
        sel_b_s    = SRC_W'(0);
        scan_pos_s = '0;
        scan_src_s = SRC_W'(0);
        for (int k = 0; k < NUM_SRC; k++) begin
            scan_pos_s = {1'b0, rr_ptr_q} + (SRC_W + 1)'(k);
            if (scan_pos_s >= (SRC_W + 1)'(NUM_SRC)) begin
                scan_pos_s = scan_pos_s - (SRC_W + 1)'(NUM_SRC);
            end else begin
                scan_pos_s = scan_pos_s;
            end
            scan_src_s = scan_pos_s[SRC_W-1:0];
            if (!empty_s[scan_src_s]) begin
                if (!found_a_s) begin
                    found_a_s = 1'b1;
                    sel_a_s   = scan_src_s;
                end else if (!found_b_s) begin
                    found_b_s = 1'b1;
                    sel_b_s   = scan_src_s;
                end else begin
                    found_b_s = found_b_s;
                end
            end else begin
                scan_src_s = scan_src_s;
            end
        end
        grant_a_s = found_a_s & ~bus.flush;
        // Duplicate destination on B is held back so both ports never hit one preg.
        grant_b_s = found_b_s & ~bus.flush & (head_s[sel_b_s].idx != head_s[sel_a_s].idx);
    end

    // Pop strobes for granted heads and the round-robin pointer update.
    always_comb begin
        pop_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pop_s[i] = (grant_a_s & (sel_a_s == SRC_W'(i)))
                     | (grant_b_s & (sel_b_s == SRC_W'(i)));
        end
        if (grant_b_s) begin
            rr_ptr_d = next_src(sel_b_s);
        end else if (grant_a_s) begin
            rr_ptr_d = next_src(sel_a_s);
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Write-port next state; idx/data hold their last value when not granted.
    always_comb begin
        wr0_en_d = grant_a_s;
        wr1_en_d = grant_b_s;
        if (grant_a_s) begin
            wr0_idx_d  = head_s[sel_a_s].idx;
            wr0_data_d = head_s[sel_a_s].data;
        end else begin
            wr0_idx_d  = wr0_idx_q;
            wr0_data_d = wr0_data_q;
        end
        if (grant_b_s) begin
            wr1_idx_d  = head_s[sel_b_s].idx;
            wr1_data_d = head_s[sel_b_s].data;
        end else begin
            wr1_idx_d  = wr1_idx_q;
            wr1_data_d = wr1_data_q;
        end
    end

    // Arbitration pointer and registered write ports.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q   <= SRC_W'(0);
            wr0_en_q   <= 1'b0;
            wr0_idx_q  <= PREG_W'(0);
            wr0_data_q <= 64'd0;
            wr1_en_q   <= 1'b0;
            wr1_idx_q  <= PREG_W'(0);
            wr1_data_q <= 64'd0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            wr0_en_q   <= wr0_en_d;
            wr0_idx_q  <= wr0_idx_d;
            wr0_data_q <= wr0_data_d;
            wr1_en_q   <= wr1_en_d;
            wr1_idx_q  <= wr1_idx_d;
            wr1_data_q <= wr1_data_d;
        end
    end

    assign bus.write0_en   = wr0_en_q;
    assign bus.write0_idx  = wr0_idx_q;
    assign bus.write0_data = wr0_data_q;
    assign bus.write1_en   = wr1_en_q;
    assign bus.write1_idx  = wr1_idx_q;
    assign bus.write1_data = wr1_data_q;

endmodule
